// File: rtl/mips_mc_control_pkg.sv
// mips_mc_control_pkg: state codes, opcodes and select encodings for the multi-cycle MIPS control FSM
package mips_mc_control_pkg;
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      ADDI_EXEC = 4'd9,
      ADDI_WB   = 4'd10,
      BRANCH    = 4'd11,
      JUMP      = 4'd12,
      JAL       = 4'd13,
      TRAP      = 4'd15
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [2:0] ULA_ADD   = 3'b000;
   localparam logic [2:0] ULA_SUB   = 3'b001;
   localparam logic [2:0] ULA_FUNCT = 3'b010;
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;
   localparam logic [1:0] PC_ULA    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;
   localparam logic [1:0] DST_RA = 2'b10;
   function automatic logic is_final(state_t s);
      return s inside {MEM_WB, MEM_WRITE, R_WB, ADDI_WB, BRANCH, JUMP, JAL};
   endfunction
endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts mem_ready-low cycles spent in one memory state and flags the last tolerated one
module mc_wait_timer #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic en,
   input  logic mem_ready,
   output logic timeout
);
   localparam int CW = WAIT_LIMIT > 1 ? $clog2(WAIT_LIMIT) : 1;
   logic [CW-1:0] cnt;
   always_ff @(posedge clock or negedge reset)
      if (!reset) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (en && !mem_ready) cnt <= cnt + CW'(1);
   assign timeout = (WAIT_LIMIT > 0) && en && !mem_ready && (cnt == CW'(WAIT_LIMIT - 1));
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout and illegal-opcode trap
module mips_mc_control
   import mips_mc_control_pkg::*;
#(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic [1:0]       RegDst,
   output logic             isJAL,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ula_operation,
   output logic [1:0]       PCSource,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] instr_count
);
   state_t cur, nxt;
   logic timeout;
   assign state = cur;
   // any state change restarts the wait count, so each memory state starts from zero
   mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
      .clock     (clock),
      .reset     (reset),
      .clear     (nxt != cur),
      .en        (cur inside {FETCH, MEM_READ, MEM_WRITE}),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         cur         <= IDLE;
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
         instr_count <= '0;
      end else begin
         cur <= nxt;
         if (cur == DECODE && nxt == TRAP) illegal_op <= 1'b1;
         if (timeout) mem_timeout <= 1'b1;
         if (is_final(cur) && nxt == FETCH) instr_count <= instr_count + CNT_W'(1);
      end
   always_comb begin
      nxt           = cur;
      PCWrite       = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = 1'b0;
      RegDst        = DST_RT;
      isJAL         = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_REG;
      ula_operation = ULA_ADD;
      PCSource      = PC_ULA;
      case (cur)
         IDLE: nxt = FETCH;
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            nxt     = mem_ready ? DECODE : timeout ? TRAP : FETCH;
         end
         DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
            case (opcode)
               OP_RTYPE:      nxt = R_EXEC;
               OP_LW, OP_SW:  nxt = MEM_ADDR;
               OP_ADDI:       nxt = ADDI_EXEC;
               OP_BEQ, OP_BNE: nxt = BRANCH;
               OP_J:          nxt = JUMP;
               OP_JAL:        nxt = JAL;
               default:       nxt = TRAP;
            endcase
         end
         MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            nxt     = opcode == OP_SW ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            nxt     = mem_ready ? MEM_WB : timeout ? TRAP : MEM_READ;
         end
         MEM_WB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            nxt      = FETCH;
         end
         MEM_WRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            nxt      = mem_ready ? FETCH : timeout ? TRAP : MEM_WRITE;
         end
         R_EXEC: begin
            ALUSrcA       = 1'b1;
            ula_operation = ULA_FUNCT;
            nxt           = R_WB;
         end
         R_WB: begin
            RegDst   = DST_RD;
            RegWrite = 1'b1;
            nxt      = FETCH;
         end
         ADDI_EXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            nxt     = ADDI_WB;
         end
         ADDI_WB: begin
            RegWrite = 1'b1;
            nxt      = FETCH;
         end
         BRANCH: begin
            ALUSrcA       = 1'b1;
            ula_operation = ULA_SUB;
            PCSource      = PC_BRANCH;
            PCWrite       = opcode == OP_BNE ? ~zero : zero;
            nxt           = FETCH;
         end
         JUMP: begin
            PCSource = PC_JUMP;
            PCWrite  = 1'b1;
            nxt      = FETCH;
         end
         JAL: begin
            PCSource = PC_JUMP;
            PCWrite  = 1'b1;
            RegDst   = DST_RA;
            isJAL    = 1'b1;
            RegWrite = 1'b1;
            nxt      = FETCH;
         end
         TRAP: nxt = TRAP;
         default: nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: directed per-scenario checks of state sequence, control vectors and status flags
module tb_mips_mc_control;
   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, isJAL, RegWrite, ALUSrcA;
   logic [1:0]  RegDst, ALUSrcB, PCSource;
   logic [2:0]  ula_operation;
   logic [3:0]  state;
   logic        illegal_op, mem_timeout;
   logic [31:0] instr_count;
   logic [17:0] ctl;
   int vec = 0;
   int errs = 0;

   // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,isJAL,RegWrite,ALUSrcA,ALUSrcB,ula,PCSource}
   assign ctl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, isJAL, RegWrite,
                 ALUSrcA, ALUSrcB, ula_operation, PCSource};
   localparam logic [17:0] C_ZERO = 18'b0;
   localparam logic [17:0] C_FR  = 18'b1_0_1_0_1_0_00_0_0_0_01_000_00;
   localparam logic [17:0] C_FN  = 18'b0_0_1_0_0_0_00_0_0_0_01_000_00;
   localparam logic [17:0] C_DEC = 18'b0_0_0_0_0_0_00_0_0_0_11_000_00;
   localparam logic [17:0] C_REX = 18'b0_0_0_0_0_0_00_0_0_1_00_010_00;
   localparam logic [17:0] C_RWB = 18'b0_0_0_0_0_0_01_0_1_0_00_000_00;
   localparam logic [17:0] C_MAD = 18'b0_0_0_0_0_0_00_0_0_1_10_000_00;
   localparam logic [17:0] C_MRD = 18'b0_1_1_0_0_0_00_0_0_0_00_000_00;
   localparam logic [17:0] C_MWB = 18'b0_0_0_0_0_1_00_0_1_0_00_000_00;
   localparam logic [17:0] C_MWR = 18'b0_1_0_1_0_0_00_0_0_0_00_000_00;
   localparam logic [17:0] C_AWB = 18'b0_0_0_0_0_0_00_0_1_0_00_000_00;
   localparam logic [17:0] C_BRT = 18'b1_0_0_0_0_0_00_0_0_1_00_001_01;
   localparam logic [17:0] C_BRN = 18'b0_0_0_0_0_0_00_0_0_1_00_001_01;
   localparam logic [17:0] C_JMP = 18'b1_0_0_0_0_0_00_0_0_0_00_000_10;
   localparam logic [17:0] C_JAL = 18'b1_0_0_0_0_0_10_1_1_0_00_000_10;

   mips_mc_control #(.WAIT_LIMIT(4), .CNT_W(32)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .isJAL(isJAL), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ula_operation(ula_operation), .PCSource(PCSource), .state(state),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout), .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
      repeat (3) step();
      vec++;
      if ({state, ctl, illegal_op, mem_timeout, instr_count} !== {4'd0, C_ZERO, 1'b0, 1'b0, 32'd0}) begin
         errs++;
         $display("FAIL reset: state=%0d ctl=%h ill=%b to=%b cnt=%0d, want 0 0 0 0 0",
                  state, ctl, illegal_op, mem_timeout, instr_count);
      end
      reset = 1'b1;
   endtask

   task automatic test_rtype();
      logic [3:0]  s [6];
      logic [17:0] c [6];
      s = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
      c = '{C_ZERO, C_FR, C_DEC, C_REX, C_RWB, C_FR};
      for (int i = 0; i < 6; i++) begin
         #1;
         vec++;
         if ({state, ctl} !== {s[i], c[i]}) begin
            errs++;
            $display("FAIL rtype[%0d]: state=%0d ctl=%h, want state=%0d ctl=%h", i, state, ctl, s[i], c[i]);
         end
         if (i < 5) step();
      end
      vec++;
      if (instr_count !== 32'd1) begin
         errs++;
         $display("FAIL rtype count: got %0d want 1", instr_count);
      end
   endtask

   task automatic test_lw();
      logic [3:0]  s [8];
      logic        r [8];
      logic [17:0] c [8];
      s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
      r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      c = '{C_FR, C_DEC, C_MAD, C_MRD, C_MRD, C_MRD, C_MWB, C_FR};
      opcode = 6'b100011;
      for (int i = 0; i < 8; i++) begin
         mem_ready = r[i];
         #1;
         vec++;
         if ({state, ctl} !== {s[i], c[i]}) begin
            errs++;
            $display("FAIL lw[%0d]: state=%0d ctl=%h, want state=%0d ctl=%h", i, state, ctl, s[i], c[i]);
         end
         if (i < 7) step();
      end
      vec++;
      if (instr_count !== 32'd2) begin
         errs++;
         $display("FAIL lw count: got %0d want 2", instr_count);
      end
   endtask

   task automatic test_branch();
      logic [5:0]  op [4];
      logic        z  [4];
      logic [17:0] c  [4];
      op = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
      z  = '{1'b1, 1'b0, 1'b0, 1'b1};
      c  = '{C_BRT, C_BRN, C_BRT, C_BRN};
      for (int k = 0; k < 4; k++) begin
         opcode = op[k]; zero = z[k];
         step();
         step();
         vec++;
         if ({state, ctl} !== {4'd11, c[k]}) begin
            errs++;
            $display("FAIL branch[%0d]: state=%0d ctl=%h, want state=11 ctl=%h", k, state, ctl, c[k]);
         end
         step();
      end
      vec++;
      if ({state, instr_count} !== {4'd1, 32'd6}) begin
         errs++;
         $display("FAIL branch end: state=%0d cnt=%0d, want 1 6", state, instr_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  op [16];
      logic [3:0]  s  [16];
      logic        r  [16];
      logic [17:0] c  [16];
      op = '{6'b101011, 6'b101011, 6'b101011, 6'b101011, 6'b101011,
             6'b001000, 6'b001000, 6'b001000, 6'b001000,
             6'b000010, 6'b000010, 6'b000010,
             6'b000011, 6'b000011, 6'b000011, 6'b000011};
      s  = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd1, 4'd2, 4'd9, 4'd10,
             4'd1, 4'd2, 4'd12, 4'd1, 4'd2, 4'd13, 4'd1};
      r  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      c  = '{C_FR, C_DEC, C_MAD, C_MWR, C_MWR, C_FR, C_DEC, C_MAD, C_AWB,
             C_FR, C_DEC, C_JMP, C_FR, C_DEC, C_JAL, C_FR};
      for (int i = 0; i < 16; i++) begin
         opcode = op[i]; mem_ready = r[i];
         #1;
         vec++;
         if ({state, ctl} !== {s[i], c[i]}) begin
            errs++;
            $display("FAIL b2b[%0d]: state=%0d ctl=%h, want state=%0d ctl=%h", i, state, ctl, s[i], c[i]);
         end
         if (i < 15) step();
      end
      vec++;
      if (instr_count !== 32'd10) begin
         errs++;
         $display("FAIL b2b count: got %0d want 10", instr_count);
      end
   endtask

   task automatic test_illegal();
      opcode = 6'b111111;
      step();
      step();
      for (int i = 0; i < 20; i++) begin
         vec++;
         if ({state, ctl, illegal_op, mem_timeout, instr_count} !== {4'd15, C_ZERO, 1'b1, 1'b0, 32'd10}) begin
            errs++;
            $display("FAIL trap[%0d]: state=%0d ctl=%h ill=%b to=%b cnt=%0d, want 15 0 1 0 10",
                     i, state, ctl, illegal_op, mem_timeout, instr_count);
         end
         step();
      end
      reset = 1'b0;
      #1;
      vec++;
      if ({state, ctl, illegal_op, instr_count} !== {4'd0, C_ZERO, 1'b0, 32'd0}) begin
         errs++;
         $display("FAIL async reset: state=%0d ctl=%h ill=%b cnt=%0d, want 0 0 0 0",
                  state, ctl, illegal_op, instr_count);
      end
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_timeout();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         vec++;
         if ({state, ctl, mem_timeout} !== {4'd1, C_FN, 1'b0}) begin
            errs++;
            $display("FAIL wait[%0d]: state=%0d ctl=%h to=%b, want 1 %h 0", i, state, ctl, mem_timeout, C_FN);
         end
         step();
      end
      vec++;
      if ({state, ctl, mem_timeout, illegal_op} !== {4'd15, C_ZERO, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL timeout: state=%0d ctl=%h to=%b ill=%b, want 15 0 1 0", state, ctl, mem_timeout, illegal_op);
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      for (int i = 0; i < 3; i++) step();
      mem_ready = 1'b1;
      opcode = 6'b101011;
      #1;
      vec++;
      if ({state, ctl} !== {4'd1, C_FR}) begin
         errs++;
         $display("FAIL ready on 4th: state=%0d ctl=%h, want 1 %h", state, ctl, C_FR);
      end
      step();
      vec++;
      if ({state, mem_timeout} !== {4'd2, 1'b0}) begin
         errs++;
         $display("FAIL no trap: state=%0d to=%b, want 2 0", state, mem_timeout);
      end
      mem_ready = 1'b0;
      step();
      step();
      vec++;
      if ({state, ctl} !== {4'd6, C_MWR}) begin
         errs++;
         $display("FAIL sw wait: state=%0d ctl=%h, want 6 %h", state, ctl, C_MWR);
      end
      reset = 1'b0;
      #1;
      vec++;
      if ({state, ctl} !== {4'd0, C_ZERO}) begin
         errs++;
         $display("FAIL reset in write: state=%0d ctl=%h, want 0 0", state, ctl);
      end
      step();
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw();
      test_branch();
      test_back_to_back();
      test_illegal();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
